// File: rtl/qcw_ramp_ctrl.sv
// Burst sequencer for the QCW bridge oscillator: ramps phase_shift once per RF cycle.
// Optional post-burst lockout (COOL state) is built in when QCW_RAMP_COOLDOWN_EN is defined.
module qcw_ramp_ctrl #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk_logic,
  input  logic             reset_n,
  input  logic             fire,
  input  logic             abort,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] ramp_start,
  input  logic [WIDTH-1:0] ramp_end,
  input  logic [WIDTH-1:0] ramp_step,
  input  logic [CNT_W-1:0] burst_cycles,
  input  logic [CNT_W-1:0] cooldown_cycles,
  input  logic             cycle_done,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] phase_shift,
  output logic             load,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_COOL  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lim;
  logic [WIDTH-1:0] r_step;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_lim_in;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_next;
  logic [CNT_W-1:0] w_cnt_dec;

  // Phase limit is the lower of the requested end point and half the RF period.
  assign w_half    = period_in >> 1;
  assign w_lim_in  = (ramp_end < w_half) ? ramp_end : w_half;
  assign w_first   = (ramp_start < w_lim_in) ? ramp_start : w_lim_in;
  assign w_sum     = {1'b0, phase_shift} + {1'b0, r_step};
  assign w_next    = (w_sum < {1'b0, r_lim}) ? w_sum[WIDTH-1:0] : r_lim;
  assign w_cnt_dec = r_cnt - CNT_W'(1);

  assign o_dbg_state = r_state;

`ifdef QCW_RAMP_COOLDOWN_EN
  logic [CNT_W-1:0] r_cool;
  logic [CNT_W-1:0] r_cool_len;
`else
  logic w_unused_cool;
  assign w_unused_cool = ^cooldown_cycles;
`endif

  always_ff @(posedge clk_logic or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_lim       <= '0;
      r_step      <= '0;
      r_cnt       <= '0;
      period      <= '0;
      phase_shift <= '0;
      load        <= 1'b0;
      enable      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
`ifdef QCW_RAMP_COOLDOWN_EN
      r_cool      <= '0;
      r_cool_len  <= '0;
`endif
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fire) begin
            if (burst_cycles == '0) begin
              done <= 1'b1;
            end else begin
              r_lim       <= w_lim_in;
              r_step      <= ramp_step;
              r_cnt       <= burst_cycles;
              aborted     <= 1'b0;
              period      <= period_in;
              phase_shift <= w_first;
              load        <= 1'b1;
              enable      <= 1'b1;
              busy        <= 1'b1;
              r_state     <= ST_RUN;
`ifdef QCW_RAMP_COOLDOWN_EN
              r_cool_len  <= cooldown_cycles;
`endif
            end
          end
        end
        ST_RUN: begin
          // abort wins over a coincident cycle_done: no phase update that cycle.
          if (abort) begin
            enable  <= 1'b0;
            aborted <= 1'b1;
            r_state <= ST_DRAIN;
          end else if (cycle_done) begin
            r_cnt <= w_cnt_dec;
            if (w_cnt_dec == '0) begin
              enable  <= 1'b0;
              r_state <= ST_DRAIN;
            end else begin
              phase_shift <= w_next;
              load        <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // The oscillator's final wrap after enable dropped ends the burst.
          if (abort || cycle_done) begin
            done <= 1'b1;
`ifdef QCW_RAMP_COOLDOWN_EN
            r_cool  <= r_cool_len;
            r_state <= ST_COOL;
`else
            busy    <= 1'b0;
            r_state <= ST_IDLE;
`endif
          end
        end
        ST_COOL: begin
`ifdef QCW_RAMP_COOLDOWN_EN
          // A zero cooldown still spends one cycle here.
          if (r_cool <= CNT_W'(1)) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cool <= r_cool - CNT_W'(1);
          end
`else
          busy    <= 1'b0;
          r_state <= ST_IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qcw_ramp_ctrl.sv
// Self-checking bench for qcw_ramp_ctrl; ramp expectations come from a list-based model.
// Covers both builds, with and without QCW_RAMP_COOLDOWN_EN.
module tb_qcw_ramp_ctrl;
  localparam int W = 24;
  localparam int C = 16;

  logic         clk_logic = 1'b0;
  logic         reset_n   = 1'b0;
  logic         fire = 1'b0, abort = 1'b0, cycle_done = 1'b0;
  logic [W-1:0] period_in = '0, ramp_start = '0, ramp_end = '0, ramp_step = '0;
  logic [C-1:0] burst_cycles = '0, cooldown_cycles = '0;
  logic [W-1:0] period, phase_shift;
  logic         load, enable, busy, done, aborted;
  logic [1:0]   o_dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];

`ifdef QCW_RAMP_COOLDOWN_EN
  localparam logic BUSY_AT_DONE = 1'b1;
`else
  localparam logic BUSY_AT_DONE = 1'b0;
`endif

  qcw_ramp_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk_logic(clk_logic), .reset_n(reset_n), .fire(fire), .abort(abort),
    .period_in(period_in), .ramp_start(ramp_start), .ramp_end(ramp_end),
    .ramp_step(ramp_step), .burst_cycles(burst_cycles),
    .cooldown_cycles(cooldown_cycles), .cycle_done(cycle_done),
    .period(period), .phase_shift(phase_shift), .load(load), .enable(enable),
    .busy(busy), .done(done), .aborted(aborted), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk_logic = ~clk_logic;

  // Every load pulse contributes one phase value to the observed list.
  always @(negedge clk_logic) if (load) act_q.push_back(phase_shift);

  task automatic tick();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Reference: lim = min(end, period/2); first = min(start, lim); each later cycle adds step, clamped.
  task automatic build_exp(input longint p, input longint s, input longint e,
                           input longint st, input int n);
    longint lim, v;
    exp_q.delete();
    lim = (e < p / 2) ? e : p / 2;
    v = (s < lim) ? s : lim;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(W'(v));
      v = (v + st < lim) ? v + st : lim;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy === 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_timeout busy=%b want 0", tag, busy);
    end
  endtask

  task automatic run_ramp(input logic [W-1:0] p, input logic [W-1:0] s, input logic [W-1:0] e,
                          input logic [W-1:0] st, input int n, input string tag);
    build_exp(p, s, e, st, n);
    act_q.delete();
    period_in = p; ramp_start = s; ramp_end = e; ramp_step = st;
    burst_cycles = C'(n); fire = 1'b1;
    tick();
    fire = 1'b0;
    // Scramble inputs: they must already be latched.
    period_in = W'($urandom); ramp_start = W'($urandom); ramp_end = W'($urandom);
    ramp_step = W'($urandom); burst_cycles = C'($urandom);
    total++;
    if (enable !== 1'b1 || busy !== 1'b1 || load !== 1'b1 || period !== p || phase_shift !== exp_q[0]) begin
      bad++;
      $display("FAIL %s start en=%b busy=%b load=%b period=%0d phase=%0d want 1 1 1 %0d %0d",
               tag, enable, busy, load, period, phase_shift, p, exp_q[0]);
    end
    for (int i = 1; i <= n; i++) begin
      gap();
      cycle_done = 1'b1;
      tick();
      cycle_done = 1'b0;
      total++;
      if (i < n) begin
        if (load !== 1'b1 || enable !== 1'b1 || phase_shift !== exp_q[i] || period !== p) begin
          bad++;
          $display("FAIL %s step%0d load=%b en=%b phase=%0d period=%0d want 1 1 %0d %0d",
                   tag, i, load, enable, phase_shift, period, exp_q[i], p);
        end
      end else if (load !== 1'b0 || enable !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s last_cd load=%b en=%b busy=%b done=%b want 0 0 1 0",
                 tag, load, enable, busy, done);
      end
    end
    gap();
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    total++;
    if (done !== 1'b1 || enable !== 1'b0 || busy !== BUSY_AT_DONE) begin
      bad++;
      $display("FAIL %s drain_done done=%b en=%b busy=%b want 1 0 %b", tag, done, enable, busy, BUSY_AT_DONE);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_width done=%b want 0", tag, done);
    end
    total++;
    if (act_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s load_count got=%0d want %0d", tag, act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (act_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL %s seq[%0d] got=%0d want %0d", tag, i, act_q[i], exp_q[i]);
        end
      end
    end
    wait_idle(tag);
  endtask

  task automatic test_reset();
    total++;
    if ({period, phase_shift, load, enable, busy, done, aborted, o_dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_held outputs=%h want 0",
               {period, phase_shift, load, enable, busy, done, aborted});
    end
    #3 reset_n = 1'b1;
    tick();
    tick();
    total++;
    if ({period, phase_shift, load, enable, busy, done, aborted} !== '0) begin
      bad++;
      $display("FAIL reset_release outputs=%h want 0",
               {period, phase_shift, load, enable, busy, done, aborted});
    end
  endtask

  task automatic test_zero_length();
    burst_cycles = '0; period_in = 24'd777; fire = 1'b1;
    tick();
    fire = 1'b0;
    total++;
    if (done !== 1'b1 || enable !== 1'b0 || busy !== 1'b0 || load !== 1'b0 || period !== '0) begin
      bad++;
      $display("FAIL zero_len done=%b en=%b busy=%b load=%b period=%0d want 1 0 0 0 0",
               done, enable, busy, load, period);
    end
    tick();
    total++;
    if (done !== 1'b0 || enable !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_after done=%b en=%b want 0 0", done, enable);
    end
  endtask

  task automatic test_basic_ramp();
    cooldown_cycles = C'(2);
    run_ramp(24'd400, 24'd0, 24'd200, 24'd50, 6, "basic_ramp");
  endtask

  task automatic test_clamp();
    run_ramp(24'd100, 24'd80, 24'd500, 24'd7, 5, "clamp_half");
    run_ramp(24'hFFFFFF, 24'd10, 24'hFFFFFF, 24'hFFFFF0, 4, "no_wrap");
    run_ramp(24'd1000, 24'd123, 24'd400, 24'd0, 4, "flat");
  endtask

  task automatic test_abort();
    logic [W-1:0] ph;
    period_in = 24'd1000; ramp_start = 24'd10; ramp_end = 24'd400; ramp_step = 24'd20;
    burst_cycles = C'(8); fire = 1'b1;
    tick();
    fire = 1'b0;
    repeat (2) begin
      cycle_done = 1'b1; tick(); cycle_done = 1'b0; tick();
    end
    ph = 24'd50;
    cycle_done = 1'b1; abort = 1'b1;
    tick();
    cycle_done = 1'b0; abort = 1'b0;
    total++;
    if (load !== 1'b0 || enable !== 1'b0 || aborted !== 1'b1 || busy !== 1'b1 || phase_shift !== ph) begin
      bad++;
      $display("FAIL abort_run load=%b en=%b aborted=%b busy=%b phase=%0d want 0 0 1 1 %0d",
               load, enable, aborted, busy, phase_shift, ph);
    end
    repeat (2) tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_drain_wait done=%b busy=%b want 0 1", done, busy);
    end
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    total++;
    if (done !== 1'b1 || aborted !== 1'b1) begin
      bad++;
      $display("FAIL abort_done done=%b aborted=%b want 1 1", done, aborted);
    end
    wait_idle("abort_run");
    abort = 1'b1; tick(); abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b1) begin
      bad++;
      $display("FAIL abort_idle busy=%b done=%b aborted=%b want 0 0 1", busy, done, aborted);
    end
    // Abort while draining ends the burst at once.
    burst_cycles = C'(1); fire = 1'b1; tick(); fire = 1'b0;
    total++;
    if (aborted !== 1'b0 || enable !== 1'b1) begin
      bad++;
      $display("FAIL abort_clear aborted=%b en=%b want 0 1", aborted, enable);
    end
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    total++;
    if (done !== 1'b1 || enable !== 1'b0) begin
      bad++;
      $display("FAIL abort_drain done=%b en=%b want 1 0", done, enable);
    end
    wait_idle("abort_drain");
  endtask

  task automatic test_ignored_fire();
    build_exp(600, 0, 300, 100, 4);
    act_q.delete();
    period_in = 24'd600; ramp_start = 24'd0; ramp_end = 24'd300; ramp_step = 24'd100;
    burst_cycles = C'(4); fire = 1'b1; tick(); fire = 1'b0;
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    period_in = 24'd50; burst_cycles = '0; fire = 1'b1; tick(); fire = 1'b0;
    total++;
    if (period !== 24'd600 || load !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || phase_shift !== 24'd100) begin
      bad++;
      $display("FAIL fire_in_run period=%0d load=%b done=%b busy=%b phase=%0d want 600 0 0 1 100",
               period, load, done, busy, phase_shift);
    end
    repeat (4) begin
      cycle_done = 1'b1; tick(); cycle_done = 1'b0; tick();
    end
    total++;
    if (act_q.size() != exp_q.size() || act_q[act_q.size()-1] !== exp_q[exp_q.size()-1]) begin
      bad++;
      $display("FAIL fire_in_run_seq count=%0d want %0d", act_q.size(), exp_q.size());
    end
    wait_idle("fire_in_run");
  endtask

  task automatic test_async_reset();
    period_in = 24'd800; ramp_start = 24'd0; ramp_end = 24'd400; ramp_step = 24'd40;
    burst_cycles = C'(10); fire = 1'b1; tick(); fire = 1'b0;
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (enable !== 1'b0 || load !== 1'b0 || busy !== 1'b0 || period !== '0 || phase_shift !== '0 || o_dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL async_reset en=%b load=%b busy=%b period=%0d phase=%0d state=%0d want all 0",
               enable, load, busy, period, phase_shift, o_dbg_state);
    end
    tick();
    #2 reset_n = 1'b1;
    tick();
    run_ramp(24'd800, 24'd20, 24'd390, 24'd90, 6, "after_reset");
  endtask

  task automatic test_back_to_back();
    period_in = 24'd300; ramp_start = 24'd5; ramp_end = 24'd100; ramp_step = 24'd10;
    burst_cycles = C'(1); cooldown_cycles = C'(10); fire = 1'b1; tick(); fire = 1'b0;
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done done=%b want 1", done);
    end
    period_in = 24'd500;
`ifdef QCW_RAMP_COOLDOWN_EN
    repeat (4) tick();
    fire = 1'b1; tick(); fire = 1'b0;
    total++;
    if (enable !== 1'b0 || busy !== 1'b1 || period !== 24'd300) begin
      bad++;
      $display("FAIL cool_fire5 en=%b busy=%b period=%0d want 0 1 300", enable, busy, period);
    end
    repeat (5) tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cool_end busy=%b want 0", busy);
    end
    fire = 1'b1; tick(); fire = 1'b0;
`else
    tick();
    fire = 1'b1; tick(); fire = 1'b0;
`endif
    total++;
    if (enable !== 1'b1 || busy !== 1'b1 || period !== 24'd500 || phase_shift !== 24'd5) begin
      bad++;
      $display("FAIL b2b_accept en=%b busy=%b period=%0d phase=%0d want 1 1 500 5",
               enable, busy, period, phase_shift);
    end
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_done done=%b want 1", done);
    end
    wait_idle("b2b");
  endtask

  task automatic test_random();
    logic [W-1:0] p, s, e, st;
    int n;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          p  = W'($urandom_range(50, 2000));
          s  = W'($urandom_range(0, 1000));
          e  = W'($urandom_range(0, 1200));
          st = W'($urandom_range(0, 300));
        end
        1: begin
          p = W'($urandom); s = W'($urandom); e = W'($urandom); st = W'($urandom);
        end
        default: begin
          p = W'($urandom_range(2, 5000)); s = W'($urandom_range(0, 3000));
          e = W'($urandom_range(0, 3000)); st = '0;
        end
      endcase
      n = $urandom_range(1, 9);
      cooldown_cycles = C'($urandom_range(0, 3));
      run_ramp(p, s, e, st, n, "random");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    #20;
    test_reset();
    test_zero_length();
    test_basic_ramp();
    test_clamp();
    test_abort();
    test_ignored_fire();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
